fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the write port of one asynchronous FIFO instance between NREQ packet requesters in the write clock domain.
- Grants one requester at a time for a whole burst, terminated by a last flag or a MAXBURST cap.
- Muxes the granted requester's data onto the FIFO write port and gates writes with FIFO full.
- Sits between producer blocks and the FIFO write side (w_en/w_data/w_full/w_counter).

Parameters:
- NREQ, 4, number of requesters (2..8).
- DATAWIDTH, 8, FIFO data width.
- ADDRWIDTH, 6, FIFO address width; w_counter is ADDRWIDTH+1 bits.
- FIFODEPTH, 44, FIFO depth in words.
- MAXBURST, 16, maximum words per grant (1..FIFODEPTH).

Ports:
- w_clk  in  1  write-domain clock.
- w_rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester word valid.
- req_last  in  NREQ  per-requester last word of packet.
- req_data  in  NREQ*DATAWIDTH  requester i occupies bits [i*DATAWIDTH +: DATAWIDTH].
- req_ack  out  NREQ  word accepted this cycle (combinational).
- grant  out  NREQ  one-hot current owner, registered.
- fifo_w_en  out  1  FIFO write enable (combinational).
- fifo_w_data  out  DATAWIDTH  FIFO write data (combinational mux).
- fifo_w_full  in  1  FIFO full.
- fifo_w_counter  in  ADDRWIDTH+1  FIFO fill level.
- burst_trunc  out  1  one-cycle pulse when a grant is cut at MAXBURST, registered.

Behaviour:
- Reset values: grant=0, rr_ptr=NREQ-1, beat_cnt=0, state=IDLE, burst_trunc=0. Combinational outputs are 0 while grant=0.
- States: IDLE, BURST.
- IDLE, entry condition: any req_valid bit is set.
  - Select the first set bit scanning rr_ptr+1, rr_ptr+2, ... modulo NREQ.
  - Register grant one-hot, set rr_ptr to the winner, clear beat_cnt, go to BURST.
  - Arbitration latency is 1 cycle; no ack is issued in IDLE.
- BURST, per cycle:
  - ack_i = grant[i] & req_valid[i] & ~fifo_w_full.
  - fifo_w_en = |ack.
  - fifo_w_data = req_data of the granted requester, or 0 when no grant.
- On ack:
  - beat_cnt increments.
  - If req_last is set: clear grant, go to IDLE.
  - Else if beat_cnt+1 == MAXBURST: clear grant, pulse burst_trunc, go to IDLE.
- Non-granted requesters never see ack. A granted requester with req_valid low simply stalls; the grant is held indefinitely.
- fifo_w_full high: no ack and no write; the state is held. A FIFO write is never issued while full.
- Re-arbitration: one bubble cycle in IDLE after each burst. The requester just served has lowest priority next round.
- If the winner drops req_valid in the grant cycle, the grant is still held (stall behaviour).
- beat_cnt width: clog2(MAXBURST+1). It never wraps past MAXBURST.
- Asynchronous reset mid-burst: immediate return to reset values. A partially written packet stays in the FIFO; cleanup is the consumer's job.

Optional Feature:
- Macro: FIFO_WR_ARB_WATERMARK_EN.
- Defined:
  - IDLE grants only when free = FIFODEPTH - fifo_w_counter >= MAXBURST.
  - free is computed in ADDRWIDTH+1 bits, unsigned.
  - Otherwise stay in IDLE with grant=0 and rr_ptr unchanged.
  - A granted burst therefore never stalls on full unless the FIFO is externally reset.
- Undefined: grant is issued regardless of fill level, and stalls are handled by fifo_w_full.

Decomposition:
- Shared package fifo_arb_pkg holds:
  - state enum (IDLE, BURST);
  - clog2 function;
  - default MAXBURST constant.
- One sub-module: rr_pick, a combinational round-robin priority selector.
  - Inputs: req vector and rr_ptr.
  - Outputs: one-hot winner and its index.
- Top level holds the FSM, counters and data mux.

Test Plan:
- Single requester: req0 sends 3 words (A1,A2,A3 with last) -> grant[0] one cycle after valid; 3 consecutive fifo_w_en writes in order; grant clears; burst_trunc stays 0.
- All 4 requesters continuously valid, 1-word packets -> grant order 0,1,2,3,0; one idle cycle between grants.
- Full stall: fifo_w_full forced high for 5 cycles mid-burst -> fifo_w_en=0 and req_ack=0 during the stall; grant held; data order preserved after release.
- MAXBURST=16, req1 streams 20 words without last -> 16 writes, burst_trunc pulses once, grant passes to the next valid requester.
- Watermark (macro defined), FIFODEPTH=44, fifo_w_counter=30 (free 14 < 16) -> no grant; drop to 28 (free 16) -> grant issued next cycle.
- w_rst_n asserted mid-burst -> grant, fifo_w_en and req_ack go to 0 immediately; after release, arbitration restarts from requester 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port round-robin arbiter.
// Holds the FSM state encoding, a constant clog2 and the default burst cap.
package fifo_arb_pkg;

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_BURST = 1'b1;

   typedef enum logic [0:0] {
      IDLE  = S_IDLE,
      BURST = S_BURST
   } state_t;

   localparam int DEF_MAXBURST = 16;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request bit strictly after
// ptr, wrapping modulo NREQ; ptr itself has the lowest priority.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDXW = clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDXW-1:0] ptr,
   output logic [NREQ-1:0] winner,
   output logic [IDXW-1:0] index,
   output logic            any
);

   logic [IDXW-1:0] cand;

   always_comb begin
      // NOTE: every output gets a default first so no path through the loop infers a latch.
      winner = '0;
      index  = '0;
      any    = 1'b0;
      cand   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = IDXW'((int'(ptr) + k) % NREQ);
         if (!any && req[cand]) begin
            any          = 1'b1;
            winner[cand] = 1'b1;
            index        = cand;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NREQ requesters.
// Define FIFO_WR_ARB_WATERMARK_EN to grant only when a full burst fits.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NREQ      = 4,
   parameter int DATAWIDTH = 8,
   parameter int ADDRWIDTH = 6,
   parameter int FIFODEPTH = 44,
   parameter int MAXBURST  = DEF_MAXBURST
) (
   input  logic                      w_clk,
   input  logic                      w_rst_n,
   input  logic [NREQ-1:0]           req_valid,
   input  logic [NREQ-1:0]           req_last,
   input  logic [NREQ*DATAWIDTH-1:0] req_data,
   output logic [NREQ-1:0]           req_ack,
   output logic [NREQ-1:0]           grant,
   output logic                      fifo_w_en,
   output logic [DATAWIDTH-1:0]      fifo_w_data,
   input  logic                      fifo_w_full,
   input  logic [ADDRWIDTH:0]        fifo_w_counter,
   output logic                      burst_trunc
);

   localparam int IDXW = clog2(NREQ);
   localparam int BW   = clog2(MAXBURST + 1);
   localparam int AW1  = ADDRWIDTH + 1;
   localparam logic [BW-1:0] BEAT_LAST = BW'(MAXBURST - 1);

   state_t          state;
   logic [IDXW-1:0] rr_ptr;
   logic [BW-1:0]   beat_cnt;

   logic [NREQ-1:0] winner;
   logic [IDXW-1:0] win_idx;
   logic            win_any;
   logic            room;
   logic            accept;
   logic            last_hit;

   rr_pick #(
      .NREQ (NREQ),
      .IDXW (IDXW)
   ) u_rr_pick (
      .req    (req_valid),
      .ptr    (rr_ptr),
      .winner (winner),
      .index  (win_idx),
      .any    (win_any)
   );

`ifdef FIFO_WR_ARB_WATERMARK_EN
   localparam logic [ADDRWIDTH:0] DEPTH_W = AW1'(FIFODEPTH);
   localparam logic [ADDRWIDTH:0] BURST_W = AW1'(MAXBURST);

   logic [ADDRWIDTH:0] free_words;

   // Unsigned subtraction at counter width; a granted burst always fits.
   assign free_words = DEPTH_W - fifo_w_counter;
   assign room       = (free_words >= BURST_W);
`else
   logic unused_counter;

   assign unused_counter = ^fifo_w_counter;
   assign room           = 1'b1;
`endif

   // grant is zero outside BURST, so ack and the write strobe are too.
   assign req_ack   = grant & req_valid & {NREQ{~fifo_w_full}};
   assign accept    = |req_ack;
   assign last_hit  = |(req_ack & req_last);
   assign fifo_w_en = accept;

   always_comb begin
      fifo_w_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) fifo_w_data = fifo_w_data | req_data[i*DATAWIDTH +: DATAWIDTH];
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         state       <= IDLE;
         grant       <= '0;
         rr_ptr      <= IDXW'(NREQ - 1);
         beat_cnt    <= '0;
         burst_trunc <= 1'b0;
      end else begin
         burst_trunc <= 1'b0;
         case (state)
            IDLE: begin
               if (win_any && room) begin
                  grant    <= winner;
                  rr_ptr   <= win_idx;
                  beat_cnt <= '0;
                  state    <= BURST;
               end
            end
            BURST: begin
               if (accept) begin
                  beat_cnt <= beat_cnt + 1'b1;
                  if (last_hit) begin
                     grant <= '0;
                     state <= IDLE;
                  end else if (beat_cnt == BEAT_LAST) begin
                     grant       <= '0;
                     burst_trunc <= 1'b1;
                     state       <= IDLE;
                  end
               end
            end
            default: begin
               grant <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

   a_grant_onehot : assert property (@(posedge w_clk) disable iff (!w_rst_n) $onehot0(grant));
   a_no_write_full : assert property (@(posedge w_clk) disable iff (!w_rst_n) !(fifo_w_en && fifo_w_full));
   a_idle_no_grant : assert property (@(posedge w_clk) disable iff (!w_rst_n) (state == IDLE) |-> (grant == '0));

endmodule
